outmap_wr_arbiter: RTL and testbench

Round-robin write scheduler that shares one memory write port between NUM_CH output-map compressor lanes. Each lane presents a packed 64-bit compressed word with a request; the block grants one lane per cycle, generates a per-lane sequential byte address from a configured base, and buffers the word in a one-entry output register toward memory. It tracks per-lane word counts and limits, and signals completion once every lane has flushed and the port has drained.

---
 rtl/outmap_wr_arbiter_pkg.sv | 16 +
 rtl/outmap_wr_arbiter_rr_arbiter.sv | 31 +++
 rtl/outmap_wr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_outmap_wr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outmap_wr_arbiter_pkg.sv
// Shared types for the output-map write arbiter: scheduler states and the compressed word.
// Combinational definitions only.
package outmap_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int WORD_BYTES = 8;

    typedef logic [63:0] cword_t;

endpackage

// File: rtl/outmap_wr_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr (wrapping); combinational, zero latency.
// No backpressure of its own; the caller qualifies the grant.
module outmap_wr_arbiter_rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_CH);
            if (!gnt_vld && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/outmap_wr_arbiter.sv
// Shares one memory write port among NUM_CH compressor lanes; grant to wr_valid is 1 cycle.
// A held word stalls all grants until wr_ready; ch_ack is withheld while the register is full.
module outmap_wr_arbiter
    import outmap_wr_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_start,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  cfg_base_addr,
    input  logic [NUM_CH-1:0][CNT_W-1:0]   cfg_word_limit,
    input  logic [NUM_CH-1:0]              ch_req,
    input  cword_t [NUM_CH-1:0]            ch_data,
    input  logic [NUM_CH-1:0]              ch_flush,
    output logic [NUM_CH-1:0]              ch_ack,
    output logic                           wr_valid,
    output logic [ADDR_W-1:0]              wr_addr,
    output cword_t                         wr_data,
    input  logic                           wr_ready,
    output logic [NUM_CH-1:0][CNT_W-1:0]   ch_word_count,
    output logic [NUM_CH-1:0]              err_overflow,
    output logic                           busy,
    output logic                           all_done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                         state_q, state_d;
    logic [NUM_CH-1:0][ADDR_W-1:0]  base_q, base_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   limit_q, limit_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]              flushed_q, flushed_d;
    logic [NUM_CH-1:0]              err_q, err_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
    cword_t                         wr_data_q, wr_data_d;

    logic [NUM_CH-1:0] below_lim;
    logic [NUM_CH-1:0] at_lim;
    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;
    logic              cap_ok;
    logic              grant;

    always_comb begin
        below_lim = '0;
        at_lim    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            below_lim[i] = (cnt_q[i] < limit_q[i]);
            at_lim[i]    = (cnt_q[i] == limit_q[i]);
        end
    end

    // A lane flushing this cycle is still eligible: its flag only takes effect next cycle.
    assign arb_req = (state_q == ST_RUN) ? (ch_req & ~flushed_q & ~err_q & below_lim) : '0;

    outmap_wr_arbiter_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign cap_ok = ~wr_valid_q | wr_ready;
    assign grant  = (state_q == ST_RUN) & cap_ok & arb_vld;
    assign ch_ack = grant ? arb_gnt : '0;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        limit_d    = limit_q;
        cnt_d      = cnt_q;
        flushed_d  = flushed_q;
        err_d      = err_q;
        rr_ptr_d   = rr_ptr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    state_d   = ST_RUN;
                    base_d    = cfg_base_addr;
                    limit_d   = cfg_word_limit;
                    cnt_d     = '0;
                    flushed_d = '0;
                    err_d     = '0;
                    rr_ptr_d  = '0;
                end
            end
            ST_RUN: begin
                if (grant) begin
                    wr_valid_d     = 1'b1;
                    wr_addr_d      = base_q[arb_idx]
                                   + ADDR_W'(cnt_q[arb_idx]) * ADDR_W'(WORD_BYTES);
                    wr_data_d      = ch_data[arb_idx];
                    cnt_d[arb_idx] = cnt_q[arb_idx] + CNT_W'(1);
                    rr_ptr_d       = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0
                                   : arb_idx + IDX_W'(1);
                end
                err_d     = err_q | (ch_req & at_lim);
                flushed_d = flushed_q | ch_flush;
                if (&(flushed_q | err_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!wr_valid_q || wr_ready) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            limit_q    <= '0;
            cnt_q      <= '0;
            flushed_q  <= '0;
            err_q      <= '0;
            rr_ptr_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            limit_q    <= limit_d;
            cnt_q      <= cnt_d;
            flushed_q  <= flushed_d;
            err_q      <= err_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign ch_word_count = cnt_q;
    assign err_overflow  = err_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign all_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_outmap_wr_arbiter.sv
// Randomized bench for outmap_wr_arbiter against a cycle-level reference of the lane/port rules.
module tb_outmap_wr_arbiter;

    localparam int N       = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  cfg_start;
    logic [N-1:0][31:0]    cfg_base_addr;
    logic [N-1:0][15:0]    cfg_word_limit;
    logic [N-1:0]          ch_req;
    logic [N-1:0][63:0]    ch_data;
    logic [N-1:0]          ch_flush;
    logic [N-1:0]          ch_ack;
    logic                  wr_valid;
    logic [31:0]           wr_addr;
    logic [63:0]           wr_data;
    logic                  wr_ready;
    logic [N-1:0][15:0]    ch_word_count;
    logic [N-1:0]          err_overflow;
    logic                  busy;
    logic                  all_done;

    outmap_wr_arbiter #(
        .NUM_CH (N),
        .ADDR_W (32),
        .CNT_W  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_word_limit (cfg_word_limit),
        .ch_req         (ch_req),
        .ch_data        (ch_data),
        .ch_flush       (ch_flush),
        .ch_ack         (ch_ack),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .ch_word_count  (ch_word_count),
        .err_overflow   (err_overflow),
        .busy           (busy),
        .all_done       (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the port and each lane should look like per the lane rules.
    int          m_st;
    int          m_rr;
    int          m_ack;
    int          m_cnt [N];
    int          m_lim [N];
    bit          m_fl  [N];
    bit          m_err [N];
    logic [31:0] m_base [N];
    bit          m_wv;
    logic [31:0] m_wa;
    logic [63:0] m_wd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_rr = 0; m_ack = -1;
        m_wv = 0; m_wa = '0; m_wd = '0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_lim[i] = 0; m_fl[i] = 0; m_err[i] = 0; m_base[i] = '0;
        end
    endtask

    // Advance the reference by one clock using the inputs present at this edge.
    task automatic model_step();
        bit wv0;
        bit all_fin;
        int st0;
        wv0 = m_wv;
        st0 = m_st;
        all_fin = 1;
        for (int i = 0; i < N; i++) if (!(m_fl[i] || m_err[i])) all_fin = 0;
        if (m_wv && wr_ready) m_wv = 0;
        if (st0 == S_IDLE || st0 == S_DONE) begin
            if (cfg_start) begin
                m_st = S_RUN; m_rr = 0;
                for (int i = 0; i < N; i++) begin
                    m_base[i] = cfg_base_addr[i];
                    m_lim[i]  = int'(cfg_word_limit[i]);
                    m_cnt[i] = 0; m_fl[i] = 0; m_err[i] = 0;
                end
            end
        end else if (st0 == S_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (ch_req[i] && m_cnt[i] == m_lim[i]) m_err[i] = 1;
                if (ch_flush[i]) m_fl[i] = 1;
            end
            if (m_ack >= 0) begin
                m_wv = 1;
                m_wa = m_base[m_ack] + 32'(m_cnt[m_ack]) * 32'd8;
                m_wd = ch_data[m_ack];
                m_cnt[m_ack]++;
                m_rr = (m_ack + 1) % N;
            end
            if (all_fin) m_st = S_DRAIN;
        end else begin
            if (!wv0 || wr_ready) m_st = S_DONE;
        end
    endtask

    // One clock: predict the grant, compare everything at negedge, then advance at posedge.
    task automatic tick();
        logic [63:0] e;
        int l;
        @(negedge clk);
        m_ack = -1;
        if (m_st == S_RUN && (!m_wv || wr_ready)) begin
            for (int k = 0; k < N; k++) begin
                l = (m_rr + k) % N;
                if (m_ack < 0 && ch_req[l] && !m_fl[l] && !m_err[l] && m_cnt[l] < m_lim[l])
                    m_ack = l;
            end
        end
        e = (m_ack >= 0) ? (64'(1) << m_ack) : 64'(0);
        chk("ch_ack", 64'(ch_ack), e);
        chk("wr_valid", 64'(wr_valid), 64'(m_wv));
        if (m_wv) begin
            chk("wr_addr", 64'(wr_addr), 64'(m_wa));
            chk("wr_data", wr_data, m_wd);
        end
        e = '0;
        for (int i = 0; i < N; i++) e[i*16 +: 16] = 16'(m_cnt[i]);
        chk("word_count", 64'(ch_word_count), e);
        e = '0;
        for (int i = 0; i < N; i++) e[i] = m_err[i];
        chk("err_overflow", 64'(err_overflow), e);
        chk("busy", 64'(busy), 64'(m_st == S_RUN || m_st == S_DRAIN));
        chk("all_done", 64'(all_done), 64'(m_st == S_DONE));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic scramble_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_base_addr[i]  = $urandom;
            cfg_word_limit[i] = 16'($urandom_range(0, 3));
        end
    endtask

    task automatic start_cfg(input logic [31:0] b [N], input int l [N]);
        for (int i = 0; i < N; i++) begin
            cfg_base_addr[i]  = b[i];
            cfg_word_limit[i] = 16'(l[i]);
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        scramble_cfg();
    endtask

    // Lanes each offer words[i] words, then pulse flush; lanes in error drop their request.
    task automatic run_lanes(input int words [N], input int ready_pct, input int req_pct,
                             input int stall_at, input int budget, input bit poke_start);
        int left [N];
        bit fsent [N];
        int cyc;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            left[i] = words[i]; fsent[i] = 0;
        end
        ch_req = '0; ch_flush = '0;
        while (m_st != S_DONE && cyc < budget) begin
            for (int i = 0; i < N; i++) begin
                ch_flush[i] = 1'b0;
                if (m_ack == i) begin
                    left[i]--;
                    ch_req[i] = 1'b0;
                end
                if (m_err[i]) begin
                    ch_req[i] = 1'b0;
                end else if (!ch_req[i] && left[i] > 0 && $urandom_range(0, 99) < req_pct) begin
                    ch_req[i]  = 1'b1;
                    ch_data[i] = {$urandom, $urandom};
                end
                if (left[i] == 0 && !fsent[i]) begin
                    ch_flush[i] = 1'b1;
                    fsent[i] = 1;
                end
            end
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5)
                wr_ready = 1'b0;
            else
                wr_ready = ($urandom_range(0, 99) < ready_pct);
            cfg_start = poke_start && ($urandom_range(0, 15) == 0);
            tick();
            cyc++;
        end
        ch_req = '0; ch_flush = '0; cfg_start = 1'b0;
        chk("reached_done", 64'(all_done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b [N];
        int          l [N];
        int          w [N];

        rst_n = 1'b0; cfg_start = 1'b0; ch_req = '0; ch_flush = '0; wr_ready = 1'b1;
        ch_data = '0; cfg_base_addr = '0; cfg_word_limit = '0;
        model_reset();
        #1;
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_ack", 64'(ch_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single lane 0, base 0x1000, limit 4.
        b = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
        l = '{4, 4, 4, 4};
        start_cfg(b, l);
        run_lanes('{4, 0, 0, 0}, 100, 100, -1, 100, 0);

        // All lanes continuously requesting, full throughput.
        b = '{32'h0, 32'h100, 32'h200, 32'h300};
        l = '{16, 16, 16, 16};
        start_cfg(b, l);
        run_lanes('{10, 10, 10, 10}, 100, 100, -1, 200, 0);
        chk("rr_counts", 64'(ch_word_count), 64'h000a_000a_000a_000a);

        // Five-cycle wr_ready stall with a word held.
        start_cfg(b, l);
        run_lanes('{6, 6, 6, 6}, 100, 100, 4, 200, 0);

        // Lane 2 overflows its limit of 2.
        l = '{5, 5, 2, 5};
        start_cfg(b, l);
        run_lanes('{3, 3, 3, 3}, 100, 100, -1, 200, 0);
        chk("ovf_err", 64'(err_overflow), 64'h4);
        chk("ovf_cnt2", 64'(ch_word_count[2]), 64'd2);
        chk("ovf_cnt0", 64'(ch_word_count[0]), 64'd3);

        // Lane 1 requests and flushes in the same cycle.
        l = '{4, 4, 4, 4};
        start_cfg(b, l);
        wr_ready = 1'b1;
        ch_flush = 4'b1111;
        ch_req   = 4'b0010;
        ch_data[1] = {$urandom, $urandom};
        tick();
        ch_req = '0; ch_flush = '0;
        for (int c = 0; c < 10 && m_st != S_DONE; c++) tick();
        chk("flush_same_cnt1", 64'(ch_word_count[1]), 64'd1);
        chk("flush_same_done", 64'(all_done), 64'd1);

        // Randomized runs, including zero limits, address wrap and ignored cfg_start.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                b[i] = (i == 3) ? 32'hFFFF_FFF0 : {$urandom_range(0, 65535), 16'h0};
                l[i] = $urandom_range(0, 6);
                w[i] = $urandom_range(0, 8);
            end
            start_cfg(b, l);
            run_lanes(w, $urandom_range(30, 100), $urandom_range(30, 100), -1, 400, 1);
        end

        // Asynchronous reset with a word held in the output register.
        l = '{8, 8, 8, 8};
        b = '{32'h8000, 32'h9000, 32'hA000, 32'hB000};
        start_cfg(b, l);
        ch_req = '1;
        for (int i = 0; i < N; i++) ch_data[i] = {$urandom, $urandom};
        wr_ready = 1'b0;
        repeat (3) tick();
        chk("pre_rst_wv", 64'(wr_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_valid", 64'(wr_valid), 64'd0);
        chk("arst_wr_addr", 64'(wr_addr), 64'd0);
        chk("arst_wr_data", wr_data, 64'd0);
        chk("arst_count", 64'(ch_word_count), 64'd0);
        chk("arst_ack", 64'(ch_ack), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(all_done), 64'd0);
        model_reset();
        ch_req = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        start_cfg(b, l);
        run_lanes('{2, 2, 2, 2}, 100, 100, -1, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
